// File: rtl/spart_rx.sv
// Receive stage of the mini-SPART: 8N1 deserialiser on a 16x oversampled baud tick,
// with a one-byte receive buffer, data-available flag and framing-error flag.
module spart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic       rd_rx,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 4;

    localparam logic [TICK_W-1:0] MID_START = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt;
    logic [DATA_W-1:0]   shift_q, shift_nxt;
    logic [DATA_W-1:0]   rx_data_nxt;
    logic                rda_nxt;
    logic                ferr_nxt;
    logic                rxd_m, rxd_s;

    // Two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_nxt;
            bit_cnt     <= bit_nxt;
            shift_q     <= shift_nxt;
            rx_data     <= rx_data_nxt;
            rda         <= rda_nxt;
            framing_err <= ferr_nxt;
        end
    end

    // Next-state logic; a good stop bit sets rda after the read clear so set wins
    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift_q;
        rx_data_nxt = rx_data;
        rda_nxt     = rda;
        ferr_nxt    = framing_err;

        if (rd_rx) begin
            rda_nxt = 1'b0;
        end

        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                    if (tick_cnt == MID_START) begin
                        if (!rxd_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                    if (tick_cnt == LAST_TICK) begin
                        shift_nxt = {rxd_s, shift_q[DATA_W-1:1]};
                        bit_nxt   = bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = STOP;
                            tick_nxt  = '0;
                        end
                    end
                end
                STOP: begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                    if (tick_cnt == LAST_TICK) begin
                        if (rxd_s) begin
                            rx_data_nxt = shift_q;
                            rda_nxt     = 1'b1;
                            ferr_nxt    = 1'b0;
                            state_nxt   = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BRK;
                        end
                    end
                end
                BRK: begin
                    // Wait for the line to return high before hunting for a new start bit
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
